// File: rtl/uart_pkg.sv
// Shared definitions for the UART FIFO bridge.
// Holds the bus address codes, the STATUS bit map and the TX FSM state type.
package uart_pkg;

  localparam logic ADDR_DATA   = 1'b0;
  localparam logic ADDR_STATUS = 1'b1;

  localparam int ST_TX_NOT_FULL  = 0;
  localparam int ST_RX_NOT_EMPTY = 1;
  localparam int ST_TX_IDLE      = 2;
  localparam int ST_OVF          = 3;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } tx_state_e;

  function automatic logic [7:0] status_byte(input logic ovf,
                                             input logic tx_idle,
                                             input logic rx_not_empty,
                                             input logic tx_not_full);
    logic [7:0] s;
    s                  = 8'h00;
    s[ST_OVF]          = ovf;
    s[ST_TX_IDLE]      = tx_idle;
    s[ST_RX_NOT_EMPTY] = rx_not_empty;
    s[ST_TX_NOT_FULL]  = tx_not_full;
    return s;
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// Byte-wide FIFO with registered occupancy count; full/empty decode from the count only.
// Head byte is presented combinationally on rdata; push when full / pop when empty are ignored.
module byte_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [7:0]               wdata,
  output logic [7:0]               rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/uart_fifo_bridge.sv
// Byte bus to UART bridge: TX/RX FIFOs, a TX launch FSM, and an RX capture path with clear handshake.
// state     | meaning
// IDLE      | waiting for a queued byte and an idle transmitter
// START     | tx_start high for this single cycle, tx_data holds the byte
// WAIT_BUSY | waiting for the transmitter to report busy
// WAIT_DONE | waiting for the transmitter to drop busy
module uart_fifo_bridge
  import uart_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       bus_req,
  input  logic       bus_we,
  input  logic       bus_addr,
  input  logic [7:0] bus_wdata,
  output logic [7:0] bus_rdata,
  output logic       bus_ack,
  output logic       tx_start,
  output logic [7:0] tx_data,
  input  logic       tx_busy,
  input  logic       rx_ready,
  input  logic [7:0] rx_data,
  output logic       rx_clear
);

  localparam int CW = $clog2(DEPTH) + 1;

  tx_state_e   state_q, state_d;
  logic        tx_start_q, tx_start_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        rx_clear_q, rx_clear_d;
  logic        bus_ack_q, bus_ack_d;
  logic [7:0]  bus_rdata_q, bus_rdata_d;
  logic        ovf_q, ovf_d;

  logic          tx_push, tx_pop, tx_full, tx_empty;
  logic          rx_push, rx_pop, rx_full, rx_empty;
  logic [7:0]    tx_head, rx_head;
  logic [CW-1:0] tx_count, rx_count;
  logic          unused_counts;

  logic wr_data, rd_data, rd_status, tx_idle;

  assign wr_data   = bus_req && bus_we  && (bus_addr == ADDR_DATA);
  assign rd_data   = bus_req && !bus_we && (bus_addr == ADDR_DATA);
  assign rd_status = bus_req && !bus_we && (bus_addr == ADDR_STATUS);

  assign tx_push = wr_data && !tx_full;
  assign tx_pop  = (state_q == IDLE) && !tx_empty && !tx_busy;
  assign rx_pop  = rd_data && !rx_empty;
  // Skipping the cycle after a clear keeps the still-high rx_ready from being captured twice.
  assign rx_push = rx_ready && !rx_full && !rx_clear_q;
  assign tx_idle = tx_empty && (state_q == IDLE) && !tx_busy;

  assign unused_counts = ^{tx_count, rx_count};

  byte_fifo #(.DEPTH(DEPTH)) u_tx_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (tx_push),
    .pop   (tx_pop),
    .wdata (bus_wdata),
    .rdata (tx_head),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_count)
  );

  byte_fifo #(.DEPTH(DEPTH)) u_rx_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (rx_push),
    .pop   (rx_pop),
    .wdata (rx_data),
    .rdata (rx_head),
    .full  (rx_full),
    .empty (rx_empty),
    .count (rx_count)
  );

  always_comb begin
    bus_ack_d   = bus_req;
    bus_rdata_d = 8'h00;
    ovf_d       = ovf_q;
    rx_clear_d  = rx_push;
    if (rd_data && !rx_empty) bus_rdata_d = rx_head;
    if (rd_status) begin
      bus_rdata_d = status_byte(ovf_q, tx_idle, !rx_empty, !tx_full);
      ovf_d       = 1'b0;
    end
    if (wr_data && tx_full) ovf_d = 1'b1;

    state_d    = state_q;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    case (state_q)
      IDLE: begin
        if (tx_pop) begin
          state_d    = START;
          tx_start_d = 1'b1;
          tx_data_d  = tx_head;
        end
      end
      START:     state_d = WAIT_BUSY;
      WAIT_BUSY: if (tx_busy)  state_d = WAIT_DONE;
      WAIT_DONE: if (!tx_busy) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      tx_start_q  <= 1'b0;
      tx_data_q   <= 8'h00;
      rx_clear_q  <= 1'b0;
      bus_ack_q   <= 1'b0;
      bus_rdata_q <= 8'h00;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      tx_start_q  <= tx_start_d;
      tx_data_q   <= tx_data_d;
      rx_clear_q  <= rx_clear_d;
      bus_ack_q   <= bus_ack_d;
      bus_rdata_q <= bus_rdata_d;
      ovf_q       <= ovf_d;
    end
  end

  assign tx_start  = tx_start_q;
  assign tx_data   = tx_data_q;
  assign rx_clear  = rx_clear_q;
  assign bus_ack   = bus_ack_q;
  assign bus_rdata = bus_rdata_q;

endmodule

// File: tb/tb_uart_fifo_bridge.sv
// Scoreboard bench for uart_fifo_bridge: stimulus queues expected bus replies and TX bytes,
// negedge monitors pop and compare; a stub transmitter and receiver sit on the serial side.
module tb_uart_fifo_bridge;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       bus_req = 1'b0;
  logic       bus_we = 1'b0;
  logic       bus_addr = 1'b0;
  logic [7:0] bus_wdata = 8'h00;
  logic [7:0] bus_rdata;
  logic       bus_ack;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_busy = 1'b0;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_clear;

  uart_fifo_bridge #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .bus_ack   (bus_ack),
    .tx_start  (tx_start),
    .tx_data   (tx_data),
    .tx_busy   (tx_busy),
    .rx_ready  (rx_ready),
    .rx_data   (rx_data),
    .rx_clear  (rx_clear)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       chk;
    logic [7:0] data;
  } rd_exp_t;

  int         checks = 0;
  int         errors = 0;
  rd_exp_t    rd_exp[$];
  logic [7:0] tx_exp[$];
  logic [7:0] rx_model[$];
  logic       ovf_model = 1'b0;
  int         tx_start_cnt = 0;
  int         rx_clear_cnt = 0;
  logic       ack_due = 1'b0;
  logic       hold_busy = 1'b0;
  logic       stub_en = 1'b1;
  int         busy_left = 0;

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h, expected %02h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [7:0] st(input logic ovf, input logic idle, input logic rxne, input logic txnf);
    return {4'b0000, ovf, idle, rxne, txnf};
  endfunction

  // Every request must be acked exactly one cycle later.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ack_due <= 1'b0;
    else        ack_due <= bus_req;
  end

  always @(negedge clk) begin
    rd_exp_t e;
    if (rst_n) begin
      check8("bus_ack_timing", {7'd0, bus_ack}, {7'd0, ack_due});
      if (bus_ack) begin
        if (rd_exp.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_ack: rdata %02h with no access pending", bus_rdata);
        end else begin
          e = rd_exp.pop_front();
          if (e.chk) check8("bus_rdata", bus_rdata, e.data);
        end
      end
      if (tx_start) begin
        tx_start_cnt++;
        if (tx_exp.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_tx_start: tx_data %02h, expected no start", tx_data);
        end else begin
          check8("tx_data", tx_data, tx_exp.pop_front());
        end
      end
    end
  end

  // Stub transmitter (busy for 11 cycles after each start) and stub receiver (drops on clear).
  always @(negedge clk) begin
    if (!rst_n)                    busy_left = 0;
    else if (tx_start && stub_en)  busy_left = 11;
    else if (busy_left > 0)        busy_left--;
    tx_busy = hold_busy || (busy_left > 0);
    if (rst_n && rx_clear) begin
      rx_clear_cnt++;
      rx_ready = 1'b0;
    end
  end

  task automatic bus_access(input logic we, input logic addr, input logic [7:0] wd,
                            input logic chk, input logic [7:0] exp);
    rd_exp_t e;
    e.chk  = chk;
    e.data = exp;
    rd_exp.push_back(e);
    @(negedge clk);
    bus_req = 1'b1; bus_we = we; bus_addr = addr; bus_wdata = wd;
    @(negedge clk);
    bus_req = 1'b0; bus_we = 1'b0;
  endtask

  task automatic write_data(input logic [7:0] b, input logic accepted);
    if (accepted) tx_exp.push_back(b);
    else          ovf_model = 1'b1;
    bus_access(1'b1, 1'b0, b, 1'b0, 8'h00);
  endtask

  task automatic read_data();
    logic [7:0] exp;
    exp = (rx_model.size() != 0) ? rx_model.pop_front() : 8'h00;
    bus_access(1'b0, 1'b0, 8'h00, 1'b1, exp);
  endtask

  task automatic read_status(input logic idle, input logic txnf);
    logic [7:0] exp;
    exp = st(ovf_model, idle, rx_model.size() != 0, txnf);
    ovf_model = 1'b0;
    bus_access(1'b0, 1'b1, 8'h00, 1'b1, exp);
  endtask

  task automatic inject_rx(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    rx_data = b; rx_ready = 1'b1;
    while (rx_ready && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (rx_ready) begin
      errors++;
      $display("FAIL rx_clear_timeout: rx_ready still 1 after %0d cycles, expected clear", n);
      rx_ready = 1'b0;
    end else begin
      rx_model.push_back(b);
    end
  endtask

  task automatic wait_tx_drain();
    int n = 0;
    while (tx_exp.size() != 0 && n < 600) begin @(negedge clk); n++; end
    check_int("tx_drain_pending", tx_exp.size(), 0);
    tx_exp.delete();
    repeat (16) @(negedge clk);
  endtask

  task automatic check_reset_outputs();
    check8("rst_bus_ack", {7'd0, bus_ack}, 8'h00);
    check8("rst_bus_rdata", bus_rdata, 8'h00);
    check8("rst_tx_start", {7'd0, tx_start}, 8'h00);
    check8("rst_tx_data", tx_data, 8'h00);
    check8("rst_rx_clear", {7'd0, rx_clear}, 8'h00);
  endtask

  initial begin
    int c0;
    int n;
    logic [7:0] b;

    #2 check_reset_outputs();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single byte through the stub transmitter.
    c0 = tx_start_cnt;
    write_data(8'h41, 1'b1);
    wait_tx_drain();
    check_int("single_tx_starts", tx_start_cnt - c0, 1);
    read_status(1'b1, 1'b1);

    // Overflow: transmitter held busy so nine writes hit a DEPTH-deep FIFO.
    hold_busy = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i <= DEPTH; i++) write_data(8'(i), i < DEPTH);
    read_status(1'b0, 1'b0);
    read_status(1'b0, 1'b0);
    c0 = tx_start_cnt;
    hold_busy = 1'b0;
    wait_tx_drain();
    check_int("ovf_tx_starts", tx_start_cnt - c0, DEPTH);
    read_status(1'b1, 1'b1);

    // RX single byte with rx_ready held until cleared.
    c0 = rx_clear_cnt;
    inject_rx(8'h5A);
    repeat (3) @(negedge clk);
    check_int("rx_single_clear", rx_clear_cnt - c0, 1);
    read_data();
    read_status(1'b1, 1'b1);

    // Empty RX read.
    read_data();
    read_status(1'b1, 1'b1);

    // RX full back-pressure.
    for (int i = 0; i < DEPTH; i++) inject_rx(8'($urandom_range(0, 255)));
    c0 = rx_clear_cnt;
    @(negedge clk);
    rx_data = 8'hC3; rx_ready = 1'b1;
    repeat (5) @(negedge clk);
    check_int("rx_full_no_clear", rx_clear_cnt - c0, 0);
    check8("rx_full_ready_held", {7'd0, rx_ready}, 8'h01);
    read_data();
    n = 0;
    while (rx_ready && n < 10) begin @(negedge clk); n++; end
    check_int("rx_full_clear_after_read", rx_clear_cnt - c0, 1);
    if (!rx_ready) rx_model.push_back(8'hC3);
    rx_ready = 1'b0;
    read_status(1'b1, 1'b1);
    while (rx_model.size() != 0) read_data();
    read_status(1'b1, 1'b1);

    // Randomized mix of writes, receives and reads.
    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(0, 4))
        0, 1: if (tx_exp.size() < DEPTH) write_data(8'($urandom_range(0, 255)), 1'b1);
        2:    if (rx_model.size() < DEPTH) inject_rx(8'($urandom_range(0, 255)));
        3:    read_data();
        default: repeat ($urandom_range(1, 6)) @(negedge clk);
      endcase
    end
    wait_tx_drain();
    read_status(1'b1, 1'b1);
    while (rx_model.size() != 0) read_data();
    read_status(1'b1, 1'b1);

    // Reset while the FSM waits for busy from a silent transmitter.
    stub_en = 1'b0;
    c0 = tx_start_cnt;
    write_data(8'h7E, 1'b1);
    n = 0;
    while (tx_start_cnt == c0 && n < 10) begin @(negedge clk); n++; end
    check_int("stall_tx_start", tx_start_cnt - c0, 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1 check_reset_outputs();
    tx_exp.delete(); rd_exp.delete(); rx_model.delete(); ovf_model = 1'b0;
    stub_en = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    c0 = tx_start_cnt;
    repeat (4) @(negedge clk);
    check_int("post_reset_no_start", tx_start_cnt - c0, 0);
    read_status(1'b1, 1'b1);
    repeat (3) @(negedge clk);
    check_int("scoreboard_rd_left", rd_exp.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not end, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/uart_fifo_bridge.md
UART_FIFO_BRIDGE -- requirements
Module: uart_fifo_bridge

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning entries per FIFO (power of 2, >=2).
REQ-002 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port bus_req  input  1  bus access request, one cycle per access.
REQ-005 SHALL have port bus_we  input  1  1=write, 0=read.
REQ-006 SHALL have port bus_addr  input  1  0=DATA, 1=STATUS.
REQ-007 SHALL have port bus_wdata  input  8  write byte.
REQ-008 SHALL have port bus_rdata  output  8  read byte, valid with bus_ack.
REQ-009 SHALL have port bus_ack  output  1  registered, high exactly one cycle after each bus_req.
REQ-010 SHALL have port tx_start  output  1  start pulse to the serial transmitter.
REQ-011 SHALL have port tx_data  output  8  byte to the transmitter, stable while tx_start is high.
REQ-012 SHALL have port tx_busy  input  1  transmitter busy.
REQ-013 SHALL have port rx_ready  input  1  receiver holds a byte (sticky until cleared).
REQ-014 SHALL have port rx_data  input  8  received byte.
REQ-015 SHALL have port rx_clear  output  1  one-cycle clear pulse to the receiver.

Function
REQ-016 SHALL contain TX and RX FIFOs, each DEPTH deep, with registered count; full/empty SHALL be decoded from the registered count only.
REQ-017 SHALL handle a DATA write when TX not full by pushing bus_wdata; when TX full, SHALL drop the byte and set sticky flag ovf.
REQ-018 SHALL handle a DATA read when RX not empty by returning the head and popping; when RX empty, SHALL return 0x00 with no pop.
REQ-019 SHALL handle a STATUS read by returning {4'b0, ovf, tx_idle, rx_not_empty, tx_not_full}, where tx_idle = TX empty and FSM IDLE and !tx_busy; ovf SHALL clear on that read.
REQ-020 SHALL ignore STATUS writes, while still acking them.
REQ-021 SHALL run a TX FSM with states IDLE, START, WAIT_BUSY, WAIT_DONE.
REQ-022 SHALL move the TX FSM from IDLE to START when TX not empty and !tx_busy, popping the head into register tx_data.
REQ-023 SHALL drive tx_start=1 for exactly the START cycle and then move to WAIT_BUSY.
REQ-024 SHALL move the TX FSM from WAIT_BUSY to WAIT_DONE when tx_busy=1.
REQ-025 SHALL move the TX FSM from WAIT_DONE to IDLE when tx_busy=0, so back-to-back bytes need at least one idle cycle.
REQ-026 SHALL, when rx_ready=1, RX not full, and no rx_clear pulse in the previous cycle, push rx_data and pulse rx_clear for one cycle; the guard cycle prevents a double push.
REQ-027 SHALL, when rx_ready=1 and RX is full, neither push nor clear, leaving the byte held in the receiver.
REQ-028 SHALL allow a same-cycle push and pop on one FIFO, with count unchanged and both operations honoured.
REQ-029 SHALL wrap FIFO pointers modulo DEPTH, with count width clog2(DEPTH)+1.

Reset
REQ-030 SHALL, while rst_n=0, asynchronously force: FIFOs empty, pointers 0, TX FSM IDLE, ovf=0, bus_ack=0, bus_rdata=0x00, tx_start=0, tx_data=0x00, rx_clear=0.
REQ-031 SHALL discard an in-flight transmit on reset mid-operation, and SHALL NOT issue tx_start in the first cycle after rst_n rises.

Structure
REQ-032 SHALL place the address codes, status bit positions, and TX FSM state enum in shared package uart_pkg.
REQ-033 SHALL instantiate the two FIFOs from one sub-module, byte_fifo (DEPTH parameter, push/pop/full/empty/count).

Verification
REQ-034 SHALL verify: write 0x41 to DATA with a stub transmitter (busy for 11 cycles) -> one tx_start with tx_data=0x41; STATUS=0x05 after done.
REQ-035 SHALL verify: write 9 bytes 0x00..0x08 quickly with DEPTH=8 -> byte 0x08 dropped, STATUS bit3=1, then 0 on the next STATUS read; 8 bytes transmitted in order.
REQ-036 SHALL verify: hold rx_ready=1 with rx_data=0x5A until rx_clear -> exactly one push; DATA read returns 0x5A, then STATUS bit1=0.
REQ-037 SHALL verify: DATA read on empty RX -> bus_rdata=0x00, ack in 1 cycle, no state change.
REQ-038 SHALL verify: RX full and rx_ready=1 -> no rx_clear; one DATA read -> next cycle push plus rx_clear.
REQ-039 SHALL verify: rst_n low during WAIT_BUSY -> all outputs at reset values immediately, and no tx_start in the first cycle after release.
